// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared constants and helpers for the forwarding / hazard scoreboard block.
package fwd_hazard_scoreboard_pkg;

    localparam int REG_ZERO       = 0;
    localparam int FWD_RF         = 0;
    localparam int FWD_STAGE_BASE = 1;

    function automatic int fwd_sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_match_prio.sv
// One source operand compared against every forwarding stage; youngest (lowest index) wins.
module fwd_match_prio
    import fwd_hazard_scoreboard_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = fwd_sel_w(FWD_STAGES)
) (
    input  logic [REG_AW-1:0]            src_addr_i,
    input  logic                         src_used_i,
    input  logic [FWD_STAGES*REG_AW-1:0] stage_rd_i,
    input  logic [FWD_STAGES-1:0]        stage_we_i,
    output logic [SEL_W-1:0]             sel_o
);

    always_comb begin
        sel_o = SEL_W'(FWD_RF);
        if (src_used_i && (src_addr_i != REG_AW'(REG_ZERO))) begin
            // Walk oldest to youngest so the youngest match is the last write.
            for (int s = FWD_STAGES - 1; s >= 0; s--) begin
                if (stage_we_i[s] && (stage_rd_i[s*REG_AW +: REG_AW] == src_addr_i)) begin
                    sel_o = SEL_W'(s + FWD_STAGE_BASE);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forward-select generation, load-use detection and long-latency pending-write scoreboard.
module fwd_hazard_scoreboard
    import fwd_hazard_scoreboard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = fwd_sel_w(FWD_STAGES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]    src_addr_i,
    input  logic [NUM_SRC-1:0]           src_used_i,
    input  logic [FWD_STAGES*REG_AW-1:0] stage_rd_i,
    input  logic [FWD_STAGES-1:0]        stage_we_i,
    input  logic [NUM_SRC*REG_AW-1:0]    id_src_addr_i,
    input  logic [NUM_SRC-1:0]           id_src_used_i,
    input  logic                         ex_is_load_i,
    input  logic [REG_AW-1:0]            ex_rd_i,
    input  logic                         lat_issue_i,
    input  logic [REG_AW-1:0]            lat_issue_rd_i,
    input  logic                         lat_done_i,
    input  logic [REG_AW-1:0]            lat_done_rd_i,
    input  logic                         perf_clr_i,
    output logic [NUM_SRC*SEL_W-1:0]     fwd_sel_o,
    output logic                         stall_o,
    output logic [2**REG_AW-1:0]         pending_map_o,
    output logic [CNT_W-1:0]             stall_cnt_o
);

    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0]  pending_q, pending_d;
    logic [NREG-1:0]  done_mask, pend_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use, raw_haz, waw_haz, stall;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_match_prio #(
            .FWD_STAGES (FWD_STAGES),
            .REG_AW     (REG_AW),
            .SEL_W      (SEL_W)
        ) u_match (
            .src_addr_i (src_addr_i[k*REG_AW +: REG_AW]),
            .src_used_i (src_used_i[k]),
            .stage_rd_i (stage_rd_i),
            .stage_we_i (stage_we_i),
            .sel_o      (fwd_sel_o[k*SEL_W +: SEL_W])
        );
    end

    always_comb begin
        done_mask = '0;
        if (lat_done_i) begin
            done_mask[lat_done_rd_i] = 1'b1;
        end
        // A write-back landing this cycle already resolves its hazard.
        pend_eff = pending_q & ~done_mask;

        load_use = 1'b0;
        raw_haz  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used_i[k] && ex_is_load_i && (ex_rd_i != REG_AW'(REG_ZERO)) &&
                (id_src_addr_i[k*REG_AW +: REG_AW] == ex_rd_i)) begin
                load_use = 1'b1;
            end
            if (id_src_used_i[k] && (id_src_addr_i[k*REG_AW +: REG_AW] != REG_AW'(REG_ZERO)) &&
                pend_eff[id_src_addr_i[k*REG_AW +: REG_AW]]) begin
                raw_haz = 1'b1;
            end
        end
        waw_haz = lat_issue_i && (lat_issue_rd_i != REG_AW'(REG_ZERO)) && pend_eff[lat_issue_rd_i];
        stall   = load_use || raw_haz || waw_haz;
    end

    always_comb begin
        pending_d = pending_q & ~done_mask;
        if (lat_issue_i && !stall && (lat_issue_rd_i != REG_AW'(REG_ZERO))) begin
            pending_d[lat_issue_rd_i] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;

        cnt_d = cnt_q;
        if (perf_clr_i) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stall_o       = stall;
    assign pending_map_o = pending_q;
    assign stall_cnt_o   = cnt_q;

endmodule
